// File: rtl/disp_pkg.sv
// Shared seven-segment definitions: the hex-to-segment table, the blank pattern
// and the slot state type used by every display driver.
package disp_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Index 15 comes first; bit6..bit0 = a..g, active-high.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h47, 7'h4F, 7'h3D, 7'h4E,  // F E d C
    7'h1F, 7'h77, 7'h7B, 7'h7F,  // b A 9 8
    7'h70, 7'h5F, 7'h5B, 7'h33,  // 7 6 5 4
    7'h79, 7'h6D, 7'h30, 7'h7E   // 3 2 1 0
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/module_disp_dec.sv
// Hex nibble to seven-segment decoder with a forced-blank input.
module module_disp_dec
  import disp_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);

  // Segment lookup, overridden to all-off when blanked
  always_comb begin
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      seg = hex_to_seg(nib);
    end
  end

endmodule

// File: rtl/module_disp_scan.sv
// Multiplexed seven-segment scanner: double-buffered N-digit hex value, per-slot
// dead time, leading-zero blanking and a frame-boundary pulse.
module module_disp_scan
  import disp_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 27000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] data,
  input  logic                  load,
  input  logic                  lzb,
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int DW = 4 * N_DIGITS;
  localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_ON    = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_MAX   = IW'(N_DIGITS - 1);
  localparam state_t        STATE_RST = (BLANK_CYCLES == 0) ? ON : BLANK;

  generate
    if (N_DIGITS < 1 || N_DIGITS > 8) begin : g_chk_digits
      $error("module_disp_scan: N_DIGITS must be in 1..8");
    end
    if (REFRESH_DIV < 2) begin : g_chk_div
      $error("module_disp_scan: REFRESH_DIV must be at least 2");
    end
    if (BLANK_CYCLES < 0 || BLANK_CYCLES >= REFRESH_DIV) begin : g_chk_blank
      $error("module_disp_scan: BLANK_CYCLES must be below REFRESH_DIV");
    end
  endgenerate

  logic [CW-1:0]       cnt_r, cnt_nxt_s;
  logic [IW-1:0]       idx_r, idx_nxt_s;
  state_t              state_r, state_nxt_s;
  logic [DW-1:0]       staging_r, disp_r;
  logic                pending_r;
  logic                frame_done_s;
  logic [3:0]          nib_s;
  logic                lz_run_s, lz_blank_s, seg_blank_s;
  logic [N_DIGITS-1:0] an_s;

  assign frame_done_s = (idx_r == IDX_MAX) && (cnt_r == CNT_MAX);

  // Slot counter, digit index and state for the following cycle
  always_comb begin
    cnt_nxt_s   = cnt_r;
    idx_nxt_s   = idx_r;
    state_nxt_s = state_r;
    if (cnt_r == CNT_MAX) begin
      cnt_nxt_s = '0;
      if (idx_r == IDX_MAX) begin
        idx_nxt_s = '0;
      end else begin
        idx_nxt_s = idx_r + IW'(1);
      end
    end else begin
      cnt_nxt_s = cnt_r + CW'(1);
    end
    if ((BLANK_CYCLES != 0) && (cnt_nxt_s < CNT_ON)) begin
      state_nxt_s = BLANK;
    end else begin
      state_nxt_s = ON;
    end
  end

  // Slot FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= '0;
      idx_r   <= '0;
      state_r <= STATE_RST;
    end else begin
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
      state_r <= state_nxt_s;
    end
  end

  // Staging register and frame-aligned transfer into the displayed value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staging_r <= '0;
      pending_r <= 1'b0;
      disp_r    <= '0;
    end else begin
      if (load) begin
        staging_r <= data;
        pending_r <= 1'b1;
      end else if (frame_done_s) begin
        pending_r <= 1'b0;
      end
      if (frame_done_s && pending_r) begin
        disp_r <= staging_r;
      end
    end
  end

  // Digit select, anode drive and leading-zero run scanned from the top digit down
  always_comb begin
    an_s       = '1;
    nib_s      = 4'h0;
    lz_run_s   = 1'b1;
    lz_blank_s = 1'b0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      lz_run_s = lz_run_s & (disp_r[4*k +: 4] == 4'h0);
      if (idx_r == IW'(k)) begin
        nib_s      = disp_r[4*k +: 4];
        lz_blank_s = lzb & lz_run_s & (k != 0);
        an_s[k]    = (state_r != ON);
      end else begin
        an_s[k] = 1'b1;
      end
    end
  end

  assign seg_blank_s = (state_r != ON) | lz_blank_s;
  assign an          = an_s;
  assign frame_done  = frame_done_s;

  module_disp_dec u_dec (
    .nib   (nib_s),
    .blank (seg_blank_s),
    .seg   (seg)
  );

endmodule

// File: tb/tb_module_disp_scan.sv
// Directed bench for module_disp_scan with N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_module_disp_scan;

  logic        clk;
  logic        rst_n;
  logic [15:0] data;
  logic        load;
  logic        lzb;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int checks;
  int failures;

  module_disp_scan #(
    .N_DIGITS     (4),
    .REFRESH_DIV  (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data       (data),
    .load       (load),
    .lzb        (lzb),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 8-cycle slot of digit k starting at cnt 0; optionally pulses load at cnt ld_cnt.
  task automatic check_slot(input string tag, input int k, input logic [6:0] exp_seg,
                            input bit ld_en, input int ld_cnt, input logic [15:0] ld_data);
    logic [3:0] one;
    logic [3:0] exp_an;
    one    = 4'b0001;
    exp_an = ~(one << k);
    for (int c = 0; c < 8; c++) begin
      if (c < 2) begin
        check_val($sformatf("%s_d%0d_c%0d_an", tag, k, c), 32'(an), 32'h0000000F);
        check_val($sformatf("%s_d%0d_c%0d_seg", tag, k, c), 32'(seg), 32'h00000000);
      end else begin
        check_val($sformatf("%s_d%0d_c%0d_an", tag, k, c), 32'(an), 32'(exp_an));
        check_val($sformatf("%s_d%0d_c%0d_seg", tag, k, c), 32'(seg), 32'(exp_seg));
      end
      check_val($sformatf("%s_d%0d_c%0d_fd", tag, k, c), 32'(frame_done),
                32'((k == 3) && (c == 7)));
      if (ld_en && (c == ld_cnt)) begin
        load = 1'b1;
        data = ld_data;
      end
      tick();
      load = 1'b0;
    end
  endtask

  task automatic frame4(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                        input logic [6:0] s2, input logic [6:0] s3);
    check_slot(tag, 0, s0, 1'b0, 0, 16'h0000);
    check_slot(tag, 1, s1, 1'b0, 0, 16'h0000);
    check_slot(tag, 2, s2, 1'b0, 0, 16'h0000);
    check_slot(tag, 3, s3, 1'b0, 0, 16'h0000);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    data     = 16'h0000;
    load     = 1'b0;
    lzb      = 1'b0;

    #12;
    check_val("rst_an", 32'(an), 32'h0000000F);
    check_val("rst_seg", 32'(seg), 32'h00000000);
    check_val("rst_fd", 32'(frame_done), 32'h00000000);
    @(negedge clk);
    rst_n = 1'b1;

    // Frame 0: reset value 0 on every digit; 1A3F loaded during digit 0
    check_slot("f0", 0, 7'h7E, 1'b1, 2, 16'h1A3F);
    check_slot("f0", 1, 7'h7E, 1'b0, 0, 16'h0000);
    check_slot("f0", 2, 7'h7E, 1'b0, 0, 16'h0000);
    check_slot("f0", 3, 7'h7E, 1'b0, 0, 16'h0000);
    frame4("f1", 7'h47, 7'h79, 7'h77, 7'h30);

    // Leading-zero blanking
    lzb = 1'b1;
    check_slot("f2", 0, 7'h47, 1'b1, 0, 16'h0005);
    check_slot("f2", 1, 7'h79, 1'b0, 0, 16'h0000);
    check_slot("f2", 2, 7'h77, 1'b0, 0, 16'h0000);
    check_slot("f2", 3, 7'h30, 1'b0, 0, 16'h0000);
    check_slot("f3", 0, 7'h5B, 1'b1, 0, 16'h0000);
    check_slot("f3", 1, 7'h00, 1'b0, 0, 16'h0000);
    check_slot("f3", 2, 7'h00, 1'b0, 0, 16'h0000);
    check_slot("f3", 3, 7'h00, 1'b0, 0, 16'h0000);
    frame4("f4", 7'h7E, 7'h00, 7'h00, 7'h00);
    lzb = 1'b0;
    check_slot("f5", 0, 7'h7E, 1'b1, 0, 16'h1111);
    check_slot("f5", 1, 7'h7E, 1'b0, 0, 16'h0000);
    check_slot("f5", 2, 7'h7E, 1'b0, 0, 16'h0000);
    check_slot("f5", 3, 7'h7E, 1'b0, 0, 16'h0000);

    // Mid-frame load must not show until the next frame
    check_slot("f6", 0, 7'h30, 1'b0, 0, 16'h0000);
    check_slot("f6", 1, 7'h30, 1'b1, 3, 16'h2222);
    check_slot("f6", 2, 7'h30, 1'b0, 0, 16'h0000);
    check_slot("f6", 3, 7'h30, 1'b0, 0, 16'h0000);

    // Y staged early, X loaded in the frame_done cycle
    check_slot("f7", 0, 7'h6D, 1'b1, 1, 16'h4567);
    check_slot("f7", 1, 7'h6D, 1'b0, 0, 16'h0000);
    check_slot("f7", 2, 7'h6D, 1'b0, 0, 16'h0000);
    check_slot("f7", 3, 7'h6D, 1'b1, 7, 16'h89AB);
    frame4("f8", 7'h70, 7'h5F, 7'h5B, 7'h33);

    // Reset during digit 2 with 1234 pending
    check_slot("f9", 0, 7'h1F, 1'b1, 1, 16'h1234);
    check_slot("f9", 1, 7'h77, 1'b0, 0, 16'h0000);
    tick();
    tick();
    tick();
    check_val("pre_rst_an", 32'(an), 32'h0000000B);
    check_val("pre_rst_seg", 32'(seg), 32'h0000007B);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_an", 32'(an), 32'h0000000F);
    check_val("mid_rst_seg", 32'(seg), 32'h00000000);
    check_val("mid_rst_fd", 32'(frame_done), 32'h00000000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    frame4("r0", 7'h7E, 7'h7E, 7'h7E, 7'h7E);
    check_slot("r1", 0, 7'h7E, 1'b0, 0, 16'h0000);
    check_slot("r1", 1, 7'h7E, 1'b0, 0, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
